// File: rtl/fpa_pkg.sv
// Shared constants for the FP adder pipeline controller: stage count, tag width,
// stage indices and a small popcount helper for the valid bits.
package fpa_pkg;

    localparam int FPA_STAGES = 3;
    localparam int FPA_TAG_W  = 5;

    localparam int S_A2C = 0;
    localparam int S_C2N = 1;
    localparam int S_N2O = 2;

    function automatic logic [1:0] fpa_popcount(input logic [FPA_STAGES-1:0] v);
        logic [1:0] cnt;
        cnt = 2'd0;
        for (int i = 0; i < FPA_STAGES; i++) begin
            cnt = cnt + {1'b0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fpa_stage_slot.sv
// One pipeline stage's bookkeeping: valid+tag flop with load, clear and tag compare.
// Latency 1 (load at edge); holds when load is low; clear drops valid but keeps the tag.
import fpa_pkg::*;

module fpa_stage_slot #(
    parameter int TAG_W = FPA_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic             v_in,
    input  logic [TAG_W-1:0] t_in,
    input  logic [TAG_W-1:0] chk_tag,
    output logic             v,
    output logic [TAG_W-1:0] t,
    output logic             match
);

    logic             v_q, v_d;
    logic [TAG_W-1:0] t_q, t_d;

    always_comb begin
        v_d = v_q;
        t_d = t_q;
        if (clear) begin
            v_d = 1'b0;
        end else if (load) begin
            v_d = v_in;
            t_d = t_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            t_q <= '0;
        end else begin
            v_q <= v_d;
            t_q <= t_d;
        end
    end

    assign v     = v_q;
    assign t     = t_q;
    assign match = v_q && (t_q == chk_tag);

endmodule

// File: rtl/float_adder_pipe_ctrl.sv
// Sequencer for the 3-stage FP adder: stage enables, valid/tag tracking, flush, hazard.
// Latency 3 cycles; empty stages always load (bubbles collapse), full stalled pipe freezes.
import fpa_pkg::*;

module float_adder_pipe_ctrl #(
    parameter int TAG_W = FPA_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             in_ready,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    input  logic             out_ready,
    input  logic             flush,
    input  logic [TAG_W-1:0] chk_tag,
    output logic             hazard,
    output logic             en_a2c,
    output logic             en_c2n,
    output logic             en_n2o,
    output logic [1:0]       occupancy,
    output logic             idle
);

    logic             v_c, v_n, v_o;
    logic [TAG_W-1:0] t_c, t_n, t_o;
    logic             m_c, m_n, m_o;
    logic             go_n2o, go_c2n, go_a2c;
    logic [FPA_STAGES-1:0] v_vec;

    // Ready ripples back from writeback; a stage advances if empty or its successor advances.
    always_comb begin
        go_n2o = !v_o || out_ready;
        go_c2n = !v_n || go_n2o;
        go_a2c = !v_c || go_c2n;
    end

    // Flush overrides every enable so the datapath registers hold while valids are cleared.
    assign en_n2o   = go_n2o && !flush;
    assign en_c2n   = go_c2n && !flush;
    assign en_a2c   = go_a2c && !flush;
    assign in_ready = en_a2c;

    fpa_stage_slot #(.TAG_W(TAG_W)) u_slot_a2c (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (en_a2c),
        .clear   (flush),
        .v_in    (in_valid),
        .t_in    (in_tag),
        .chk_tag (chk_tag),
        .v       (v_c),
        .t       (t_c),
        .match   (m_c)
    );

    fpa_stage_slot #(.TAG_W(TAG_W)) u_slot_c2n (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (en_c2n),
        .clear   (flush),
        .v_in    (v_c),
        .t_in    (t_c),
        .chk_tag (chk_tag),
        .v       (v_n),
        .t       (t_n),
        .match   (m_n)
    );

    fpa_stage_slot #(.TAG_W(TAG_W)) u_slot_n2o (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (en_n2o),
        .clear   (flush),
        .v_in    (v_n),
        .t_in    (t_n),
        .chk_tag (chk_tag),
        .v       (v_o),
        .t       (t_o),
        .match   (m_o)
    );

    assign out_valid = v_o && !flush;
    assign out_tag   = t_o;

    // The op being issued this cycle is deliberately not part of the hazard check.
    assign hazard = !flush && (m_c || m_n || m_o);

    always_comb begin
        v_vec        = '0;
        v_vec[S_A2C] = v_c;
        v_vec[S_C2N] = v_n;
        v_vec[S_N2O] = v_o;
    end

    assign occupancy = fpa_popcount(v_vec);
    assign idle      = (occupancy == 2'd0);

endmodule
